// File: rtl/btb_pkg.sv
// Shared encodings and width helpers for the set-associative branch target buffer.
package btb_pkg;

  typedef enum logic {
    ENT_JUMP   = 1'b0,
    ENT_BRANCH = 1'b1
  } ent_type_e;

  typedef enum logic [1:0] {
    CTR_HOLD = 2'd0,
    CTR_INC  = 2'd1,
    CTR_DEC  = 2'd2,
    CTR_INIT = 2'd3
  } ctr_op_e;

  // Index width that stays at least one bit wide so degenerate sizes still declare legally.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int tag_bits(input int xlen, input int num_sets);
    return xlen - $clog2(num_sets) - 2;
  endfunction

  // Counter encodings are returned 3 bits wide (max CTR_BITS) and truncated by the user.
  function automatic logic [2:0] ctr_max(input int bits);
    return 3'((1 << bits) - 1);
  endfunction

  function automatic logic [2:0] ctr_weak_taken(input int bits);
    return 3'(1 << (bits - 1));
  endfunction

  function automatic logic [2:0] ctr_weak_not_taken(input int bits);
    return 3'((1 << (bits - 1)) - 1);
  endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// Next-state logic for one saturating direction counter: hold, increment, decrement or initialise.
module btb_sat_ctr
  import btb_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  ctr_op_e             op,
  input  logic                init_branch,
  input  logic                init_taken,
  input  logic [CTR_BITS-1:0] ctr_cur,
  output logic [CTR_BITS-1:0] ctr_nxt
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = CTR_BITS'(ctr_max(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    ctr_nxt = ctr_cur;
    case (op)
      CTR_INC:  if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + CTR_BITS'(1);
      CTR_DEC:  if (ctr_cur != '0)      ctr_nxt = ctr_cur - CTR_BITS'(1);
      CTR_INIT: ctr_nxt = !init_branch ? CTR_MAX : (init_taken ? CTR_WT : CTR_WNT);
      default:  ctr_nxt = ctr_cur;
    endcase
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: zero-latency lookup at fetch, resolved updates from decode,
// per-set FIFO replacement once a set is full.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int XLEN     = 32,
  parameter int CTR_BITS = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] IF_pc,
  output logic            hit,
  output logic            IF_Branch,
  output logic            IF_Jump,
  output logic            predict_taken,
  output logic [XLEN-1:0] pc_imm_out,
  input  logic            write,
  input  logic [XLEN-1:0] ID_pc,
  input  logic [XLEN-1:0] pc_imm_in,
  input  logic            ID_Branch,
  input  logic            ID_taken,
  input  logic            flush
);

  localparam int SET_BITS = $clog2(NUM_SETS);
  localparam int TAG_W    = tag_bits(XLEN, NUM_SETS);
  localparam int WAY_W    = idx_bits(NUM_WAYS);
  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_not_taken(CTR_BITS));

  logic                valid_q  [NUM_SETS][NUM_WAYS];
  ent_type_e           type_q   [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
  logic [XLEN-1:0]     target_q [NUM_SETS][NUM_WAYS];
  logic [CTR_BITS-1:0] ctr_q    [NUM_SETS][NUM_WAYS];

  logic [SET_BITS-1:0] r_set, w_set;
  logic [TAG_W-1:0]    r_tag, w_tag;
  logic                w_hit, w_free, fifo_adv;
  logic [WAY_W-1:0]    w_hit_way, w_free_way, w_way, ptr_cur;
  ctr_op_e             ctr_op;
  logic [CTR_BITS-1:0] ctr_cur, ctr_nxt;
  ent_type_e           w_type;

  // Byte offset bits never take part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc[1:0], ID_pc[1:0]};

  assign r_set  = IF_pc[SET_BITS+1:2];
  assign r_tag  = IF_pc[XLEN-1:SET_BITS+2];
  assign w_set  = ID_pc[SET_BITS+1:2];
  assign w_tag  = ID_pc[XLEN-1:SET_BITS+2];
  assign w_type = ID_Branch ? ENT_BRANCH : ENT_JUMP;

  // Lookup: descending scan so the lowest-numbered matching way is the one that sticks.
  always_comb begin
    hit           = 1'b0;
    IF_Branch     = 1'b0;
    IF_Jump       = 1'b0;
    predict_taken = 1'b0;
    pc_imm_out    = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[r_set][w] && (tag_q[r_set][w] == r_tag)) begin
        hit           = 1'b1;
        IF_Branch     = (type_q[r_set][w] == ENT_BRANCH);
        IF_Jump       = (type_q[r_set][w] == ENT_JUMP);
        predict_taken = (type_q[r_set][w] == ENT_JUMP) || ctr_q[r_set][w][CTR_BITS-1];
        pc_imm_out    = target_q[r_set][w];
      end
    end
  end

  // Update side: in-place way if ID_pc already resident, else lowest free way, else FIFO victim.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_way  = '0;
    w_free     = 1'b0;
    w_free_way = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[w_set][w] && (tag_q[w_set][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!valid_q[w_set][w]) begin
        w_free     = 1'b1;
        w_free_way = WAY_W'(w);
      end
    end
    w_way    = w_hit ? w_hit_way : (w_free ? w_free_way : ptr_cur);
    fifo_adv = write && !flush && !w_hit && !w_free;

    ctr_op = CTR_INIT;
    if (w_hit && (type_q[w_set][w_hit_way] == w_type)) begin
      if (ID_Branch) ctr_op = ID_taken ? CTR_INC : CTR_DEC;
      else           ctr_op = CTR_HOLD;
    end
  end

  assign ctr_cur = ctr_q[w_set][w_way];

  btb_sat_ctr #(
    .CTR_BITS(CTR_BITS)
  ) u_sat_ctr (
    .op         (ctr_op),
    .init_branch(ID_Branch),
    .init_taken (ID_taken),
    .ctr_cur    (ctr_cur),
    .ctr_nxt    (ctr_nxt)
  );

  generate
    if (NUM_WAYS > 1) begin : g_ptr
      logic [WAY_W-1:0] ptr_q [NUM_SETS];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
        end else if (flush) begin
          for (int s = 0; s < NUM_SETS; s++) ptr_q[s] <= '0;
        end else if (fifo_adv) begin
          ptr_q[w_set] <= (ptr_q[w_set] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr_q[w_set] + WAY_W'(1);
        end
      end

      assign ptr_cur = ptr_q[w_set];
    end else begin : g_no_ptr
      assign ptr_cur = '0;
    end
  endgenerate

  // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= CTR_WNT;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) valid_q[s][w] <= 1'b0;
      end
    end else if (write) begin
      valid_q[w_set][w_way] <= 1'b1;
      ctr_q[w_set][w_way]   <= ctr_nxt;
    end
  end

  // NOTE: tag/target/type arrays carry no reset; they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (write && !flush) begin
      tag_q[w_set][w_way]    <= w_tag;
      target_q[w_set][w_way] <= pc_imm_in;
      type_q[w_set][w_way]   <= w_type;
    end
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Scoreboard bench for btb_assoc: directed scenarios then random traffic against a way-level reference model.
module tb_btb_assoc;

  localparam int NS   = 16;
  localparam int NW   = 2;
  localparam int XL   = 32;
  localparam int CB   = 2;
  localparam int MAXC = (1 << CB) - 1;
  localparam int HALF = 1 << (CB - 1);

  typedef struct packed {
    logic          hit;
    logic          br;
    logic          jmp;
    logic          pt;
    logic [XL-1:0] tgt;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [XL-1:0] IF_pc = '0;
  logic          hit, IF_Branch, IF_Jump, predict_taken;
  logic [XL-1:0] pc_imm_out;
  logic          write = 1'b0;
  logic [XL-1:0] ID_pc = '0;
  logic [XL-1:0] pc_imm_in = '0;
  logic          ID_Branch = 1'b0;
  logic          ID_taken = 1'b0;
  logic          flush = 1'b0;

  always #5 clk = ~clk;

  btb_assoc #(
    .NUM_SETS(NS),
    .NUM_WAYS(NW),
    .XLEN    (XL),
    .CTR_BITS(CB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IF_pc        (IF_pc),
    .hit          (hit),
    .IF_Branch    (IF_Branch),
    .IF_Jump      (IF_Jump),
    .predict_taken(predict_taken),
    .pc_imm_out   (pc_imm_out),
    .write        (write),
    .ID_pc        (ID_pc),
    .pc_imm_in    (pc_imm_in),
    .ID_Branch    (ID_Branch),
    .ID_taken     (ID_taken),
    .flush        (flush)
  );

  int checks = 0;
  int failures = 0;
  resp_t exp_q[$];
  string name_q[$];

  // Reference model: per set, a list of way slots plus a round-robin victim index.
  bit          m_valid[NS][NW];
  int unsigned m_tag[NS][NW];
  logic [31:0] m_tgt[NS][NW];
  bit          m_br[NS][NW];
  int          m_ctr[NS][NW];
  int          m_ptr[NS];

  function automatic int set_of(input logic [31:0] pc);
    return int'((pc / 4) % NS);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / (4 * NS);
  endfunction

  function automatic int init_ctr(input bit br, input bit tk);
    if (!br) return MAXC;
    return tk ? HALF : HALF - 1;
  endfunction

  function automatic resp_t model_lookup(input logic [31:0] pc);
    resp_t r;
    int s;
    r = '0;
    s = set_of(pc);
    for (int w = 0; w < NW; w++) begin
      if (m_valid[s][w] && m_tag[s][w] == tag_of(pc)) begin
        r.hit = 1'b1;
        r.br  = m_br[s][w];
        r.jmp = !m_br[s][w];
        r.pt  = !m_br[s][w] || (m_ctr[s][w] >= HALF);
        r.tgt = m_tgt[s][w];
        return r;
      end
    end
    return r;
  endfunction

  task automatic model_clear(input bit full_reset);
    for (int s = 0; s < NS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        if (full_reset) m_ctr[s][w] = HALF - 1;
      end
    end
  endtask

  task automatic model_write(input logic [31:0] pc, input logic [31:0] tgt, input bit br, input bit tk);
    int s, way;
    s = set_of(pc);
    way = -1;
    for (int w = 0; w < NW; w++)
      if (way < 0 && m_valid[s][w] && m_tag[s][w] == tag_of(pc)) way = w;
    if (way >= 0) begin
      if (m_br[s][way] != br) m_ctr[s][way] = init_ctr(br, tk);
      else if (br && tk && m_ctr[s][way] < MAXC) m_ctr[s][way] = m_ctr[s][way] + 1;
      else if (br && !tk && m_ctr[s][way] > 0) m_ctr[s][way] = m_ctr[s][way] - 1;
    end else begin
      for (int w = 0; w < NW; w++)
        if (way < 0 && !m_valid[s][w]) way = w;
      if (way < 0) begin
        way = m_ptr[s];
        m_ptr[s] = (m_ptr[s] + 1) % NW;
      end
      m_valid[s][way] = 1'b1;
      m_tag[s][way]   = tag_of(pc);
      m_ctr[s][way]   = init_ctr(br, tk);
    end
    m_tgt[s][way] = tgt;
    m_br[s][way]  = br;
  endtask

  task automatic check(input string name, input resp_t act, input resp_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got hit=%0b br=%0b jmp=%0b pt=%0b tgt=%h, want hit=%0b br=%0b jmp=%0b pt=%0b tgt=%h",
               name, act.hit, act.br, act.jmp, act.pt, act.tgt, exp.hit, exp.br, exp.jmp, exp.pt, exp.tgt);
    end
  endtask

  // Monitor: lookup outputs are presented every cycle; compare mid-cycle against the queued expectation.
  always @(negedge clk) begin
    resp_t a, e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      a = {hit, IF_Branch, IF_Jump, predict_taken, pc_imm_out};
      check(n, a, e);
    end
  end

  task automatic drive(input string n, input logic [31:0] lpc, input bit wr, input logic [31:0] wpc,
                       input logic [31:0] wtgt, input bit wbr, input bit wtk, input bit fl);
    IF_pc     = lpc;
    write     = wr;
    ID_pc     = wpc;
    pc_imm_in = wtgt;
    ID_Branch = wbr;
    ID_taken  = wtk;
    flush     = fl;
    exp_q.push_back(model_lookup(lpc));
    name_q.push_back(n);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (flush) model_clear(1'b0);
      else if (write) model_write(ID_pc, pc_imm_in, ID_Branch, ID_taken);
    end
    #1;
  endtask

  task automatic step(input string n, input logic [31:0] lpc, input bit wr, input logic [31:0] wpc,
                      input logic [31:0] wtgt, input bit wbr, input bit wtk, input bit fl);
    drive(n, lpc, wr, wpc, wtgt, wbr, wtk, fl);
    tick();
  endtask

  task automatic look(input string n, input logic [31:0] lpc);
    step(n, lpc, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pool_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 7)) << 6) | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) pc = pc | 32'h1000_0000;
    return pc;
  endfunction

  initial begin
    model_clear(1'b1);
    repeat (2) @(posedge clk);
    #1;
    drive("reset lookup 0x100", 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Branch install and counter walk down to saturation.
    step("install br 0x100", 32'h100, 1'b1, 32'h100, 32'h180, 1'b1, 1'b1, 1'b0);
    step("br 0x100 taken hit", 32'h100, 1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0);
    step("br 0x100 ctr 01", 32'h100, 1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0);
    step("br 0x100 ctr 00", 32'h100, 1'b1, 32'h100, 32'h180, 1'b1, 1'b0, 1'b0);
    step("br 0x100 sat 00", 32'h100, 1'b1, 32'h100, 32'h180, 1'b1, 1'b1, 1'b0);
    look("br 0x100 ctr 01 after sat", 32'h100);

    // FIFO replacement within set 0.
    step("flush before fifo", 32'h100, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    step("jmp 0x000 install", 32'h000, 1'b1, 32'h000, 32'h400, 1'b0, 1'b0, 1'b0);
    step("jmp 0x040 install", 32'h000, 1'b1, 32'h040, 32'h440, 1'b0, 1'b0, 1'b0);
    step("jmp 0x080 evicts", 32'h040, 1'b1, 32'h080, 32'h480, 1'b0, 1'b0, 1'b0);
    look("0x000 evicted", 32'h000);
    look("0x040 resident", 32'h040);
    look("0x080 resident", 32'h080);
    step("jmp 0x0c0 uses ptr 1", 32'h0C0, 1'b1, 32'h0C0, 32'h4C0, 1'b0, 1'b0, 1'b0);
    look("0x040 evicted by ptr", 32'h040);
    look("0x0c0 resident", 32'h0C0);

    // Flush with a simultaneous write.
    step("flush+write", 32'h080, 1'b1, 32'h200, 32'h280, 1'b1, 1'b1, 1'b1);
    look("write dropped by flush", 32'h200);
    look("flush cleared 0x080", 32'h080);

    // Asynchronous reset while a lookup is hitting.
    step("jmp 0x300 install", 32'h300, 1'b1, 32'h300, 32'h3A0, 1'b0, 1'b0, 1'b0);
    look("jmp 0x300 hit", 32'h300);
    rst_n = 1'b0;
    model_clear(1'b1);
    drive("reset drops hit", 32'h300, 1'b1, 32'h340, 32'h3B0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    step("post-reset miss", 32'h300, 1'b1, 32'h300, 32'h310, 1'b1, 1'b0, 1'b0);
    look("post-reset write installed", 32'h300);
    look("pending write abandoned", 32'h340);

    for (int i = 0; i < 400; i++) begin
      step("random", pool_pc(), $urandom_range(0, 2) != 0, pool_pc(), $urandom(),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
    end

    write = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
